demux_1by4: RTL and testbench



---
 rtl/demux_1by4.sv | 94 +++++++++
 tb/tb_demux_1by4.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1by4.sv
// rtl/demux_1by4.sv - registered 1-to-4 demultiplexer with one-hot routing strobes
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   s1, s0     select {s1,s0}: 0->y0, 1->y1, 2->y2, 3->y3
//   i          data to route (WIDTH bits)
//   en         route enable; 0 = no routing this cycle
//   y0..y3     registered outputs
//   v0..v3     registered one-hot strobes, vN=1 when yN was loaded on the last edge
//   sel_q      select index of the last enabled routing
// Parameters:
//   WIDTH      data width
//   HOLD       0 = non-routed outputs clear each cycle, 1 = they keep their value

module demux_1by4 #(
   parameter int WIDTH = 1,
   parameter int HOLD  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0,
   input  logic             s1,
   input  logic [WIDTH-1:0] i,
   input  logic             en,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             v0,
   output logic             v1,
   output logic             v2,
   output logic             v3,
   output logic [1:0]       sel_q
);

   logic [1:0]       sel;
   logic [3:0]       route;
   logic [WIDTH-1:0] y_q [4];
   logic [WIDTH-1:0] y_d [4];
   logic [3:0]       v_q;

   assign sel = {s1, s0};

   // One-hot of the output being loaded this cycle; all zero when disabled.
   always_comb begin
      route = 4'b0000;
      if (en) begin
         route[sel] = 1'b1;
      end
   end

   // Non-routed outputs either clear or keep their value, fixed at elaboration.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         if (route[n]) begin
            y_d[n] = i;
         end else if (HOLD != 0) begin
            y_d[n] = y_q[n];
         end else begin
            y_d[n] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) begin
            y_q[n] <= '0;
         end
         v_q   <= 4'b0000;
         sel_q <= 2'b00;
      end else begin
         for (int n = 0; n < 4; n++) begin
            y_q[n] <= y_d[n];
         end
         v_q <= route;
         // sel_q remembers the last enabled routing, so it holds while en=0.
         if (en) begin
            sel_q <= sel;
         end
      end
   end

   assign y0 = y_q[0];
   assign y1 = y_q[1];
   assign y2 = y_q[2];
   assign y3 = y_q[3];
   assign v0 = v_q[0];
   assign v1 = v_q[1];
   assign v2 = v_q[2];
   assign v3 = v_q[3];

endmodule

// File: tb/tb_demux_1by4.sv
// tb/tb_demux_1by4.sv - randomized self-checking bench for demux_1by4

module tb_demux_1by4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s0 = 1'b0;
   logic       s1 = 1'b0;
   logic       en = 1'b0;
   logic [7:0] i = 8'h00;

   always #5 clk = ~clk;

   logic       w1_y0, w1_y1, w1_y2, w1_y3, w1_v0, w1_v1, w1_v2, w1_v3;
   logic [1:0] w1_sel;
   logic [7:0] w8_y0, w8_y1, w8_y2, w8_y3;
   logic       w8_v0, w8_v1, w8_v2, w8_v3;
   logic [1:0] w8_sel;
   logic [7:0] h8_y0, h8_y1, h8_y2, h8_y3;
   logic       h8_v0, h8_v1, h8_v2, h8_v3;
   logic [1:0] h8_sel;

   demux_1by4 #(.WIDTH(1), .HOLD(0)) u_w1 (
      .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .i(i[0]), .en(en),
      .y0(w1_y0), .y1(w1_y1), .y2(w1_y2), .y3(w1_y3),
      .v0(w1_v0), .v1(w1_v1), .v2(w1_v2), .v3(w1_v3), .sel_q(w1_sel));

   demux_1by4 #(.WIDTH(8), .HOLD(0)) u_w8 (
      .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .i(i), .en(en),
      .y0(w8_y0), .y1(w8_y1), .y2(w8_y2), .y3(w8_y3),
      .v0(w8_v0), .v1(w8_v1), .v2(w8_v2), .v3(w8_v3), .sel_q(w8_sel));

   demux_1by4 #(.WIDTH(8), .HOLD(1)) u_h8 (
      .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1), .i(i), .en(en),
      .y0(h8_y0), .y1(h8_y1), .y2(h8_y2), .y3(h8_y3),
      .v0(h8_v0), .v1(h8_v1), .v2(h8_v2), .v3(h8_v3), .sel_q(h8_sel));

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: per instance, four output values, four strobes, last select.
   // Instance 0: WIDTH=1 HOLD=0, 1: WIDTH=8 HOLD=0, 2: WIDTH=8 HOLD=1.
   int         m_y   [3][4];
   int         m_v   [3][4];
   int         m_sel [3];
   const int   hold_of [3] = '{0, 0, 1};
   const int   mask_of [3] = '{1, 255, 255};

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 4; n++) begin
            m_y[k][n] = 0;
            m_v[k][n] = 0;
         end
         m_sel[k] = 0;
      end
   endtask

   task automatic model_edge();
      int target;
      target = 2 * int'(s1) + int'(s0);
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 4; n++) begin
            if (en && n == target) begin
               m_y[k][n] = int'(i) & mask_of[k];
               m_v[k][n] = 1;
            end else begin
               if (hold_of[k] == 0) m_y[k][n] = 0;
               m_v[k][n] = 0;
            end
         end
         if (en) m_sel[k] = target;
      end
   endtask

   function automatic logic [37:0] act(int k);
      case (k)
         0:       act = {7'd0, w1_y0, 7'd0, w1_y1, 7'd0, w1_y2, 7'd0, w1_y3,
                         w1_v3, w1_v2, w1_v1, w1_v0, w1_sel};
         1:       act = {w8_y0, w8_y1, w8_y2, w8_y3, w8_v3, w8_v2, w8_v1, w8_v0, w8_sel};
         default: act = {h8_y0, h8_y1, h8_y2, h8_y3, h8_v3, h8_v2, h8_v1, h8_v0, h8_sel};
      endcase
   endfunction

   function automatic logic [37:0] expect_state(int k);
      expect_state = {8'(m_y[k][0]), 8'(m_y[k][1]), 8'(m_y[k][2]), 8'(m_y[k][3]),
                      m_v[k][3] != 0, m_v[k][2] != 0, m_v[k][1] != 0, m_v[k][0] != 0,
                      2'(m_sel[k])};
   endfunction

   // Rising edge, model update, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         en = 1'b1; s0 = 1'($urandom); s1 = 1'($urandom); i = 8'($urandom);
         tick();
         for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (act(k) !== 38'd0)
               $display("FAIL reset_hold inst%0d got %h want 0", k, act(k));
            else pass_cnt++;
         end
      end
      // Release between edges; the very next edge must route normally.
      #2 rst_n = 1'b1;
      en = 1'b1; s1 = 1'b1; s0 = 1'b0; i = 8'h81;
      tick();
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act(k) !== expect_state(k))
            $display("FAIL reset_first_edge inst%0d got %h want %h", k, act(k), expect_state(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_sweep();
      logic [1:0] sels [4]  = '{2'd0, 2'd2, 2'd1, 2'd3};
      logic [3:0] ypat [4]  = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};
      for (int c = 0; c < 4; c++) begin
         en = 1'b1; i = 8'h01; {s1, s0} = sels[c];
         tick();
         total_cnt++;
         if ({w1_y0, w1_y1, w1_y2, w1_y3} !== ypat[c] ||
             {w1_v0, w1_v1, w1_v2, w1_v3} !== ypat[c] || w1_sel !== sels[c])
            $display("FAIL sweep step%0d got y=%b v=%b sel=%0d want y=v=%b sel=%0d", c,
                     {w1_y0, w1_y1, w1_y2, w1_y3}, {w1_v0, w1_v1, w1_v2, w1_v3}, w1_sel,
                     ypat[c], sels[c]);
         else pass_cnt++;
      end
   endtask

   task automatic test_hold_sequence();
      logic [1:0] sels [3] = '{2'd0, 2'd3, 2'd0};
      logic [7:0] dats [3] = '{8'h01, 8'h01, 8'h00};
      logic [3:0] ypat [3] = '{4'b1000, 4'b1001, 4'b0001};
      logic [3:0] vpat [3] = '{4'b1000, 4'b0001, 4'b1000};
      // Start from a clean slate so the expected patterns are absolute.
      rst_n = 1'b0; #1 rst_n = 1'b1; model_reset();
      for (int c = 0; c < 3; c++) begin
         en = 1'b1; i = dats[c]; {s1, s0} = sels[c];
         tick();
         total_cnt++;
         if ({h8_y0[0], h8_y1[0], h8_y2[0], h8_y3[0]} !== ypat[c] ||
             {h8_v0, h8_v1, h8_v2, h8_v3} !== vpat[c])
            $display("FAIL hold_seq step%0d got y=%b v=%b want y=%b v=%b", c,
                     {h8_y0[0], h8_y1[0], h8_y2[0], h8_y3[0]}, {h8_v0, h8_v1, h8_v2, h8_v3},
                     ypat[c], vpat[c]);
         else pass_cnt++;
      end
   endtask

   task automatic test_disable();
      en = 1'b1; i = 8'h01; s1 = 1'b1; s0 = 1'b0;
      tick();
      en = 1'b0; i = 8'hFF; s1 = 1'b1; s0 = 1'b1;
      tick();
      total_cnt++;
      if ({w8_y0, w8_y1, w8_y2, w8_y3} !== 32'd0 || {w8_v0, w8_v1, w8_v2, w8_v3} !== 4'd0 ||
          w8_sel !== 2'd2)
         $display("FAIL disable got y=%h v=%b sel=%0d want y=0 v=0 sel=2",
                  {w8_y0, w8_y1, w8_y2, w8_y3}, {w8_v0, w8_v1, w8_v2, w8_v3}, w8_sel);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act(k) !== expect_state(k))
            $display("FAIL disable_model inst%0d got %h want %h", k, act(k), expect_state(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_wide();
      en = 1'b1; i = 8'hA5; s1 = 1'b0; s0 = 1'b1;
      tick();
      total_cnt++;
      if ({w8_y0, w8_y1, w8_y2, w8_y3} !== 32'h00A50000)
         $display("FAIL wide_a5 got %h want 00a50000", {w8_y0, w8_y1, w8_y2, w8_y3});
      else pass_cnt++;
      i = 8'h3C; s1 = 1'b1; s0 = 1'b0;
      tick();
      total_cnt++;
      if ({w8_y0, w8_y1, w8_y2, w8_y3} !== 32'h00003C00)
         $display("FAIL wide_3c got %h want 00003c00", {w8_y0, w8_y1, w8_y2, w8_y3});
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      for (int c = 0; c < 4; c++) begin
         en = 1'b1; i = 8'($urandom);
         for (int g = 0; g < 3; g++) begin
            #2 s0 = 1'($urandom); s1 = 1'($urandom); i = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
               total_cnt++;
               if (act(k) !== expect_state(k))
                  $display("FAIL glitch_between inst%0d got %h want %h", k, act(k), expect_state(k));
               else pass_cnt++;
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (act(k) !== expect_state(k))
               $display("FAIL glitch_edge inst%0d got %h want %h", k, act(k), expect_state(k));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_mid_reset();
      en = 1'b1; i = 8'h01; s1 = 1'b1; s0 = 1'b1;
      tick();
      total_cnt++;
      if (w1_y3 !== 1'b1 || w1_v3 !== 1'b1 || w1_sel !== 2'd3)
         $display("FAIL mid_reset_setup got y3=%b v3=%b sel=%0d want 1 1 3", w1_y3, w1_v3, w1_sel);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act(k) !== 38'd0)
            $display("FAIL mid_reset_async inst%0d got %h want 0", k, act(k));
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (act(2) !== 38'd0)
         $display("FAIL mid_reset_held got %h want 0", act(2));
      else pass_cnt++;
      #2 rst_n = 1'b1;
      en = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (act(k) !== expect_state(k))
            $display("FAIL mid_reset_release inst%0d got %h want %h", k, act(k), expect_state(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         en = ($urandom_range(0, 3) != 0);
         s0 = 1'($urandom); s1 = 1'($urandom);
         i  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         tick();
         for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (act(k) !== expect_state(k))
               $display("FAIL random c%0d inst%0d got %h want %h", c, k, act(k), expect_state(k));
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_hold_sequence();
      test_disable();
      test_wide();
      test_glitch();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
